// File: rtl/delay_chain_sensor.sv
// delay_chain_sensor
//   Launches a level change into an external delay chain, captures the
//   asynchronous tap outputs after a programmable settle time, double-registers
//   them, counts how many taps the new level reached and accumulates that count
//   over NUM_SAMPLES launches. The sum is offered on a valid/ready handshake.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         measurement request, honoured only in IDLE
//   launch        registered level driving the chain input
//   taps          asynchronous chain tap outputs
//   busy          high whenever the FSM is not in IDLE
//   result        accumulated reached-tap count
//   result_valid  result is valid and stable
//   result_ready  consumer accepts result
//   sample_min    smallest per-sample count   (only with SPY_MINMAX_EN)
//   sample_max    largest per-sample count    (only with SPY_MINMAX_EN)
//
// Optional feature macro: SPY_MINMAX_EN
//
// state   | meaning
// IDLE    | waiting for start
// SETTLE  | launch edge issued, waiting for capture edge
// SYNC    | cap_q re-registered into sync_q
// ACCUM   | popcount of reached taps added to accumulator
// REST    | gap between samples before the next launch
// OUT     | result held until result_ready

module delay_chain_sensor #(
  parameter int                   TAP_COUNT   = 16,
  parameter logic [TAP_COUNT-1:0] TAP_POL     = '0,
  parameter int                   NUM_SAMPLES = 8,
  parameter int                   SETTLE_CYC  = 1,
  parameter int                   GAP_CYC     = 4,
  localparam int                  CW          = $clog2(NUM_SAMPLES*TAP_COUNT+1),
  localparam int                  PW          = $clog2(TAP_COUNT+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 launch,
  input  logic [TAP_COUNT-1:0] taps,
  output logic                 busy,
  output logic [CW-1:0]        result,
  output logic                 result_valid,
  input  logic                 result_ready
`ifdef SPY_MINMAX_EN
  ,
  output logic [PW-1:0]        sample_min,
  output logic [PW-1:0]        sample_max
`endif
);

  localparam int SNW  = $clog2(NUM_SAMPLES+1);
  localparam int TMAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int TW   = $clog2(TMAX+1);
  localparam logic [TW-1:0]  SETTLE_LD = TW'(SETTLE_CYC-1);
  localparam logic [TW-1:0]  GAP_LD    = TW'(GAP_CYC-1);
  localparam logic [SNW-1:0] NS        = SNW'(NUM_SAMPLES);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_SYNC, S_ACCUM, S_REST, S_OUT
  } state_t;

  state_t               state_q,  state_d;
  logic                 launch_q, launch_d;
  logic                 busy_q,   busy_d;
  logic                 valid_q,  valid_d;
  logic [TAP_COUNT-1:0] cap_q,    cap_d;
  logic [TAP_COUNT-1:0] sync_q,   sync_d;
  logic [CW-1:0]        acc_q,    acc_d;
  logic [SNW-1:0]       samp_q,   samp_d;
  logic [TW-1:0]        tmr_q,    tmr_d;
`ifdef SPY_MINMAX_EN
  logic [PW-1:0]        min_q,    min_d;
  logic [PW-1:0]        max_q,    max_d;
`endif

  logic [TAP_COUNT-1:0] reached;
  logic [PW-1:0]        pop;
  logic [SNW-1:0]       samp_inc;

  always_comb begin
    // a tap has reached the new level when it matches launch, after undoing
    // any built-in inversion of that tap
    reached  = ~(sync_q ^ {TAP_COUNT{launch_q}} ^ TAP_POL);
    pop      = '0;
    for (int i = 0; i < TAP_COUNT; i++) begin
      pop = pop + PW'(reached[i]);
    end
    samp_inc = samp_q + SNW'(1);

    state_d  = state_q;
    launch_d = launch_q;
    valid_d  = valid_q;
    cap_d    = cap_q;
    sync_d   = sync_q;
    acc_d    = acc_q;
    samp_d   = samp_q;
    tmr_d    = tmr_q;
`ifdef SPY_MINMAX_EN
    min_d    = min_q;
    max_d    = max_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          launch_d = ~launch_q;
          acc_d    = '0;
          samp_d   = '0;
          tmr_d    = SETTLE_LD;
          state_d  = S_SETTLE;
`ifdef SPY_MINMAX_EN
          min_d    = PW'(TAP_COUNT);
          max_d    = '0;
`endif
        end
      end
      S_SETTLE: begin
        if (tmr_q == '0) begin
          cap_d   = taps;
          state_d = S_SYNC;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_SYNC: begin
        sync_d  = cap_q;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        acc_d  = acc_q + CW'(pop);
        samp_d = samp_inc;
`ifdef SPY_MINMAX_EN
        if (pop < min_q) min_d = pop;
        if (pop > max_q) max_d = pop;
`endif
        if (samp_inc < NS) begin
          tmr_d   = GAP_LD;
          state_d = S_REST;
        end else begin
          valid_d = 1'b1;
          state_d = S_OUT;
        end
      end
      S_REST: begin
        if (tmr_q == '0) begin
          launch_d = ~launch_q;
          tmr_d    = SETTLE_LD;
          state_d  = S_SETTLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_OUT: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      cap_q    <= '0;
      sync_q   <= '0;
      acc_q    <= '0;
      samp_q   <= '0;
      tmr_q    <= '0;
`ifdef SPY_MINMAX_EN
      min_q    <= '0;
      max_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      cap_q    <= cap_d;
      sync_q   <= sync_d;
      acc_q    <= acc_d;
      samp_q   <= samp_d;
      tmr_q    <= tmr_d;
`ifdef SPY_MINMAX_EN
      min_q    <= min_d;
      max_q    <= max_d;
`endif
    end
  end

  assign launch       = launch_q;
  assign busy         = busy_q;
  assign result       = acc_q;
  assign result_valid = valid_q;
`ifdef SPY_MINMAX_EN
  assign sample_min   = min_q;
  assign sample_max   = max_q;
`endif

endmodule

// File: tb/tb_delay_chain_sensor.sv
// Directed bench for delay_chain_sensor. Three instances share clock and
// reset: dut_a (one sample), dut_b (four samples) and dut_c (all taps
// inverted, two samples). Each chain model drives taps from launch and a
// per-sample mask: masked taps follow launch, the rest hold the old level.

module tb_delay_chain_sensor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        start_a, ready_a, launch_a, busy_a, valid_a;
  logic [15:0] taps_a, mask_a;
  logic [4:0]  res_a;
  logic        start_b, ready_b, launch_b, busy_b, valid_b;
  logic [15:0] taps_b, mask_b;
  logic [6:0]  res_b;
  logic        start_c, ready_c, launch_c, busy_c, valid_c;
  logic [15:0] taps_c, mask_c;
  logic [5:0]  res_c;
`ifdef SPY_MINMAX_EN
  logic [4:0]  min_a, max_a, min_b, max_b, min_c, max_c;
`endif

  assign taps_a = launch_a ? mask_a : ~mask_a;
  assign taps_b = launch_b ? mask_b : ~mask_b;
  assign taps_c = launch_c ? mask_c : ~mask_c;

  delay_chain_sensor #(.NUM_SAMPLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .launch(launch_a), .taps(taps_a),
    .busy(busy_a), .result(res_a), .result_valid(valid_a), .result_ready(ready_a)
`ifdef SPY_MINMAX_EN
    , .sample_min(min_a), .sample_max(max_a)
`endif
  );

  delay_chain_sensor #(.NUM_SAMPLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .launch(launch_b), .taps(taps_b),
    .busy(busy_b), .result(res_b), .result_valid(valid_b), .result_ready(ready_b)
`ifdef SPY_MINMAX_EN
    , .sample_min(min_b), .sample_max(max_b)
`endif
  );

  delay_chain_sensor #(.NUM_SAMPLES(2), .TAP_POL(16'hFFFF)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .launch(launch_c), .taps(taps_c),
    .busy(busy_c), .result(res_c), .result_valid(valid_c), .result_ready(ready_c)
`ifdef SPY_MINMAX_EN
    , .sample_min(min_c), .sample_max(max_c)
`endif
  );

  // reached counts per sample for dut_b: 3, 7, 0, 16
  function automatic logic [15:0] mask_of(input int k);
    case (k)
      0:       mask_of = 16'h0007;
      1:       mask_of = 16'h007F;
      2:       mask_of = 16'h0000;
      default: mask_of = 16'hFFFF;
    endcase
  endfunction

  // Starts dut_b and follows it until result_valid, loading the next mask
  // after every launch toggle and recording launch spacing in cycles.
  task automatic run_b(output int tog, output int sp_min, output int sp_max, output bit tout);
    int   last;
    logic prev;
    last = 0; prev = launch_b; tog = 0; sp_min = 1000; sp_max = 0; tout = 1'b1;
    @(negedge clk); start_b = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); @(negedge clk); start_b = 1'b0;
      if (launch_b !== prev) begin
        prev = launch_b;
        if (tog > 0) begin
          if (c - last < sp_min) sp_min = c - last;
          if (c - last > sp_max) sp_max = c - last;
        end
        last = c;
        tog++;
        mask_b = mask_of(tog - 1);
      end
      if (valid_b === 1'b1) begin
        tout = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_a(output bit tout);
    tout = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (valid_a === 1'b1) begin tout = 1'b0; break; end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (launch_a !== 1'b0) begin n_err++; $display("FAIL reset_launch_a: got %b want 0", launch_a); end
    n_vec++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
    n_vec++; if (valid_c !== 1'b0) begin n_err++; $display("FAIL reset_valid_c: got %b want 0", valid_c); end
    n_vec++; if (res_b !== 7'd0) begin n_err++; $display("FAIL reset_result_b: got %0d want 0", res_b); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    mask_a = 16'h001F;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); @(negedge clk); start_a = 1'b0;
    n_vec++; if (launch_a !== 1'b1) begin n_err++; $display("FAIL single_launch: got %b want 1", launch_a); end
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy_a); end
    @(negedge clk); @(negedge clk);
    n_vec++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL single_valid_early: got %b want 0", valid_a); end
    @(negedge clk);
    n_vec++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL single_valid_edge3: got %b want 1", valid_a); end
    n_vec++; if (res_a !== 5'd5) begin n_err++; $display("FAIL single_result: got %0d want 5", res_a); end
`ifdef SPY_MINMAX_EN
    n_vec++; if (min_a !== 5'd5 || max_a !== 5'd5) begin n_err++; $display("FAIL single_minmax: got %0d/%0d want 5/5", min_a, max_a); end
`endif
    ready_a = 1'b1;
    @(negedge clk); ready_a = 1'b0;
    n_vec++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL single_valid_drop: got %b want 0", valid_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", busy_a); end
    n_vec++; if (res_a !== 5'd5) begin n_err++; $display("FAIL single_result_hold: got %0d want 5", res_a); end
  endtask

  task automatic test_accum();
    int tog, sp_min, sp_max;
    bit tout;
    run_b(tog, sp_min, sp_max, tout);
    n_vec++; if (tout) begin n_err++; $display("FAIL accum_timeout: got no result_valid want valid within 200 cycles"); end
    n_vec++; if (res_b !== 7'd26) begin n_err++; $display("FAIL accum_result: got %0d want 26", res_b); end
    n_vec++; if (tog !== 4) begin n_err++; $display("FAIL accum_toggles: got %0d want 4", tog); end
    n_vec++; if (sp_min !== 7 || sp_max !== 7) begin n_err++; $display("FAIL accum_spacing: got %0d..%0d want 7", sp_min, sp_max); end
`ifdef SPY_MINMAX_EN
    n_vec++; if (min_b !== 5'd0 || max_b !== 5'd16) begin n_err++; $display("FAIL accum_minmax: got %0d/%0d want 0/16", min_b, max_b); end
`endif
  endtask

  task automatic test_backpressure();
    logic l0;
    l0 = launch_b;
    for (int k = 0; k < 10; k++) begin
      start_b = (k % 2 == 0);
      @(posedge clk); @(negedge clk);
      n_vec++; if (valid_b !== 1'b1 || res_b !== 7'd26) begin n_err++; $display("FAIL bp_hold[%0d]: got valid=%b result=%0d want valid=1 result=26", k, valid_b, res_b); end
      n_vec++; if (busy_b !== 1'b1 || launch_b !== l0) begin n_err++; $display("FAIL bp_state[%0d]: got busy=%b launch=%b want busy=1 launch=%b", k, busy_b, launch_b, l0); end
    end
    ready_b = 1'b1; start_b = 1'b1;
    @(posedge clk); @(negedge clk);
    ready_b = 1'b0; start_b = 1'b0;
    n_vec++; if (busy_b !== 1'b0 || valid_b !== 1'b0) begin n_err++; $display("FAIL bp_release: got busy=%b valid=%b want 0/0", busy_b, valid_b); end
    n_vec++; if (res_b !== 7'd26 || launch_b !== l0) begin n_err++; $display("FAIL bp_after: got result=%0d launch=%b want 26/%b", res_b, launch_b, l0); end
    @(negedge clk);
    n_vec++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL bp_start_ignored: got busy=%b want 0", busy_b); end
  endtask

  task automatic test_polarity();
    bit tout;
    mask_c = 16'h0000;
    @(negedge clk); start_c = 1'b1;
    tout = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); @(negedge clk); start_c = 1'b0;
      if (valid_c === 1'b1) begin tout = 1'b0; break; end
    end
    n_vec++; if (tout) begin n_err++; $display("FAIL pol_timeout: got no result_valid want valid within 60 cycles"); end
    n_vec++; if (res_c !== 6'd32) begin n_err++; $display("FAIL pol_result: got %0d want 32", res_c); end
`ifdef SPY_MINMAX_EN
    n_vec++; if (min_c !== 5'd16 || max_c !== 5'd16) begin n_err++; $display("FAIL pol_minmax: got %0d/%0d want 16/16", min_c, max_c); end
`endif
    ready_c = 1'b1;
    @(negedge clk); ready_c = 1'b0;
    n_vec++; if (busy_c !== 1'b0) begin n_err++; $display("FAIL pol_idle: got %b want 0", busy_c); end
  endtask

  task automatic test_reset_mid();
    int   tog, sp_min, sp_max;
    bit   tout;
    logic prev;
    prev = launch_b; tog = 0;
    @(negedge clk); start_b = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); @(negedge clk); start_b = 1'b0;
      if (launch_b !== prev) begin
        prev = launch_b;
        tog++;
        mask_b = mask_of(tog - 1);
      end
      if (tog == 2) break;
    end
    n_vec++; if (tog !== 2) begin n_err++; $display("FAIL rmid_reach_sample2: got %0d launches want 2", tog); end
    n_vec++; if (res_b !== 7'd3 || busy_b !== 1'b1) begin n_err++; $display("FAIL rmid_pre: got result=%0d busy=%b want 3/1", res_b, busy_b); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (busy_b !== 1'b0 || valid_b !== 1'b0 || res_b !== 7'd0) begin n_err++; $display("FAIL rmid_b_cleared: got busy=%b valid=%b result=%0d want 0/0/0", busy_b, valid_b, res_b); end
    n_vec++; if (launch_a !== 1'b0 || res_a !== 5'd0) begin n_err++; $display("FAIL rmid_a_cleared: got launch=%b result=%0d want 0/0", launch_a, res_a); end
    n_vec++; if (res_c !== 6'd0) begin n_err++; $display("FAIL rmid_c_cleared: got result=%0d want 0", res_c); end
    @(negedge clk); rst_n = 1'b1;
    run_b(tog, sp_min, sp_max, tout);
    n_vec++; if (tout) begin n_err++; $display("FAIL rmid_timeout: got no result_valid want valid within 200 cycles"); end
    n_vec++; if (res_b !== 7'd26 || tog !== 4) begin n_err++; $display("FAIL rmid_rerun: got result=%0d launches=%0d want 26/4", res_b, tog); end
    ready_b = 1'b1;
    @(negedge clk); ready_b = 1'b0;
    n_vec++; if (valid_b !== 1'b0 || busy_b !== 1'b0) begin n_err++; $display("FAIL rmid_release: got valid=%b busy=%b want 0/0", valid_b, busy_b); end
  endtask

  task automatic test_back_to_back();
    bit   tout;
    logic exp_l;
    mask_a = 16'h001F;
    for (int m = 0; m < 2; m++) begin
      exp_l = (m == 0);
      @(negedge clk); start_a = 1'b1;
      @(posedge clk); @(negedge clk); start_a = 1'b0;
      n_vec++; if (launch_a !== exp_l) begin n_err++; $display("FAIL b2b_launch[%0d]: got %b want %b", m, launch_a, exp_l); end
      wait_a(tout);
      n_vec++; if (tout) begin n_err++; $display("FAIL b2b_timeout[%0d]: got no result_valid want valid within 50 cycles", m); end
      n_vec++; if (res_a !== 5'd5) begin n_err++; $display("FAIL b2b_result[%0d]: got %0d want 5", m, res_a); end
      ready_a = 1'b1;
      @(negedge clk); ready_a = 1'b0;
      n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL b2b_idle[%0d]: got %b want 0", m, busy_a); end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0; ready_a = 1'b0; mask_a = '0;
    start_b = 1'b0; ready_b = 1'b0; mask_b = '0;
    start_c = 1'b0; ready_c = 1'b0; mask_c = '0;
    test_reset();
    test_single();
    test_accum();
    test_backpressure();
    test_polarity();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
